// File: rtl/simple_tx.sv
// Packet transmitter: buffers one AXI-Stream packet, then emits SFD/type/size/payload/checksum framing.
// Optional SIMPLE_TX_PAD_EN zero-pads short packets to 8 payload bytes instead of dropping them.
module simple_tx #(
    parameter int          G_MEM_SIZE    = 256,
    parameter int          G_IFG         = 12,
    parameter logic [15:0] G_PACKET_TYPE = 16'h1234
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  s_tdata_in,
    input  logic        s_tvalid_in,
    input  logic        s_tlast_in,
    output logic        s_tready_out,
    output logic [7:0]  txd_out,
    output logic        txen_out,
    output logic        txer_out,
    output logic [15:0] stat_packet_sent_cnt,
    output logic [15:0] stat_packet_drop_cnt
);

    localparam int N_MAX = (G_MEM_SIZE < 255) ? G_MEM_SIZE : 255;
    localparam int AW    = (N_MAX > 1) ? $clog2(N_MAX) : 1;

    typedef enum logic [2:0] {
        S_FILL, S_DISCARD, S_SFD, S_TYPE, S_SIZE, S_PAYLOAD, S_FCS, S_IFG
    } state_t;

    state_t      state;
    logic [8:0]  cnt;
    logic [8:0]  n_next;
    logic [7:0]  idx;
    logic [7:0]  frame_len;
    logic [7:0]  data_len;
    logic [15:0] csum;
    logic [15:0] ifg_cnt;
    logic [7:0]  mem [N_MAX];
    logic [7:0]  pay_byte;
    logic        beat;
    logic        wr_en;

    assign beat     = s_tvalid_in && s_tready_out;
    assign n_next   = cnt + 9'd1;
    assign wr_en    = beat && (state == S_FILL) && (cnt < 9'(N_MAX));
    assign txer_out = 1'b0;

    // Bytes past the stored length are pad bytes and go out as zero.
    assign pay_byte = (idx < data_len) ? mem[idx[AW-1:0]] : 8'h00;

    // NOTE: the payload buffer has no reset; cnt/data_len decide which entries are meaningful.
    always_ff @(posedge clk_in) begin
        if (wr_en) mem[cnt[AW-1:0]] <= s_tdata_in;
    end

    function automatic logic [7:0] sfd_byte(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h7F;
            2'd1:    return 8'h55;
            2'd2:    return 8'h44;
            default: return 8'h55;
        endcase
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state                <= S_FILL;
            cnt                  <= '0;
            idx                  <= '0;
            frame_len            <= '0;
            data_len             <= '0;
            csum                 <= '0;
            ifg_cnt              <= '0;
            s_tready_out         <= 1'b0;
            txd_out              <= 8'h00;
            txen_out             <= 1'b0;
            stat_packet_sent_cnt <= '0;
            stat_packet_drop_cnt <= '0;
        end else begin
            txd_out  <= 8'h00;
            txen_out <= 1'b0;
            case (state)
                S_FILL: begin
                    s_tready_out <= 1'b1;
                    if (beat) begin
                        if (s_tlast_in) begin
                            cnt       <= '0;
                            idx       <= '0;
                            frame_len <= n_next[7:0];
                            data_len  <= n_next[7:0];
                            if (n_next >= 9'd8 && n_next <= 9'(N_MAX)) begin
                                state        <= S_SFD;
                                s_tready_out <= 1'b0;
                            end
`ifdef SIMPLE_TX_PAD_EN
                            else if (n_next < 9'd8) begin
                                state        <= S_SFD;
                                s_tready_out <= 1'b0;
                                frame_len    <= 8'd8;
                            end
`endif
                            else begin
                                stat_packet_drop_cnt <= stat_packet_drop_cnt + 16'd1;
                            end
                        end else if (cnt == 9'(N_MAX)) begin
                            state <= S_DISCARD;
                            cnt   <= '0;
                        end else begin
                            cnt <= n_next;
                        end
                    end
                end
                S_DISCARD: begin
                    s_tready_out <= 1'b1;
                    if (beat && s_tlast_in) begin
                        stat_packet_drop_cnt <= stat_packet_drop_cnt + 16'd1;
                        state                <= S_FILL;
                    end
                end
                S_SFD: begin
                    txen_out <= 1'b1;
                    txd_out  <= sfd_byte(idx[1:0]);
                    if (idx == 8'd3) begin
                        idx   <= '0;
                        state <= S_TYPE;
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end
                S_TYPE: begin
                    txen_out <= 1'b1;
                    txd_out  <= (idx == 8'd0) ? G_PACKET_TYPE[7:0] : G_PACKET_TYPE[15:8];
                    if (idx == 8'd1) begin
                        idx   <= '0;
                        state <= S_SIZE;
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end
                S_SIZE: begin
                    txen_out <= 1'b1;
                    txd_out  <= frame_len;
                    csum     <= {8'h00, G_PACKET_TYPE[15:8]} + {8'h00, G_PACKET_TYPE[7:0]}
                              + {8'h00, frame_len};
                    state    <= S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    txen_out <= 1'b1;
                    txd_out  <= pay_byte;
                    csum     <= csum + {8'h00, pay_byte};
                    if (idx == frame_len - 8'd1) begin
                        state <= S_FCS;
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end
                S_FCS: begin
                    txen_out             <= 1'b1;
                    txd_out              <= csum[7:0];
                    stat_packet_sent_cnt <= stat_packet_sent_cnt + 16'd1;
                    ifg_cnt              <= '0;
                    state                <= S_IFG;
                end
                S_IFG: begin
                    if (ifg_cnt == 16'(G_IFG - 1)) begin
                        state        <= S_FILL;
                        s_tready_out <= 1'b1;
                    end else begin
                        ifg_cnt <= ifg_cnt + 16'd1;
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_simple_tx.sv
// Self-checking bench for simple_tx: scoreboard of expected line bytes against a negedge monitor.
module tb_simple_tx;

    typedef logic [7:0] q8_t[$];

    logic        clk_in;
    logic        rst_in;
    logic [7:0]  s_tdata_in;
    logic        s_tvalid_in;
    logic        s_tlast_in;
    logic        s_tready_out;
    logic [7:0]  txd_out;
    logic        txen_out;
    logic        txer_out;
    logic [15:0] stat_packet_sent_cnt;
    logic [15:0] stat_packet_drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         exp_len_q[$];
    int         len_q[$];
    int         gap_q[$];
    int         run = 0;
    int         idle = 0;
    int         idle_bad = 0;
    int         txer_bad = 0;

    simple_tx dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .s_tdata_in           (s_tdata_in),
        .s_tvalid_in          (s_tvalid_in),
        .s_tlast_in           (s_tlast_in),
        .s_tready_out         (s_tready_out),
        .txd_out              (txd_out),
        .txen_out             (txen_out),
        .txer_out             (txer_out),
        .stat_packet_sent_cnt (stat_packet_sent_cnt),
        .stat_packet_drop_cnt (stat_packet_drop_cnt)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Line monitor: collects frame bytes, frame lengths and idle gaps preceding each frame.
    always @(negedge clk_in) begin
        if (txen_out) begin
            obs_q.push_back(txd_out);
            if (run == 0) gap_q.push_back(idle);
            run++;
            idle = 0;
        end else begin
            if (run != 0) len_q.push_back(run);
            run = 0;
            idle++;
            if (txd_out !== 8'h00) idle_bad++;
        end
        if (txer_out !== 1'b0) txer_bad++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic q8_t make_pkt(input int n, input int start, input bit rnd);
        q8_t p;
        for (int i = 0; i < n; i++) p.push_back(rnd ? 8'($urandom) : 8'(start + i));
        return p;
    endfunction

    // Reference framing: SFD, type 0x1234 LSB first, size, payload, byte-sum checksum.
    task automatic push_frame(input q8_t p);
        q8_t        q;
        logic [7:0] sum;
        logic [7:0] n;
        q = p;
`ifdef SIMPLE_TX_PAD_EN
        while (q.size() < 8) q.push_back(8'h00);
`endif
        n   = 8'(q.size());
        sum = 8'h34 + 8'h12 + n;
        exp_q.push_back(8'h7F); exp_q.push_back(8'h55);
        exp_q.push_back(8'h44); exp_q.push_back(8'h55);
        exp_q.push_back(8'h34); exp_q.push_back(8'h12);
        exp_q.push_back(n);
        foreach (q[i]) begin
            exp_q.push_back(q[i]);
            sum = sum + q[i];
        end
        exp_q.push_back(sum);
        exp_len_q.push_back(q.size() + 8);
    endtask

    task automatic send_beat(input logic [7:0] d, input bit last, output int waits);
        s_tdata_in  = d;
        s_tlast_in  = last;
        s_tvalid_in = 1'b1;
        waits       = 0;
        forever begin
            @(negedge clk_in);
            if (s_tready_out || waits > 2000) break;
            waits++;
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_pkt(input q8_t p, input bit hold, output int first_wait, output int rest_wait);
        int w;
        int worst;
        worst      = 0;
        first_wait = 0;
        rest_wait  = 0;
        foreach (p[i]) begin
            send_beat(p[i], i == p.size() - 1, w);
            if (i == 0) first_wait = w;
            else        rest_wait += w;
            if (w > worst) worst = w;
        end
        check("tready wait bounded", worst <= 2000, 1);
        if (!hold) begin
            s_tvalid_in = 1'b0;
            s_tlast_in  = 1'b0;
        end
    endtask

    task automatic compare_frames(input string tag);
        bit done;
        done = 0;
        repeat (40) @(posedge clk_in);
        for (int c = 0; c < 4000 && !done; c++) begin
            @(posedge clk_in);
            #1;
            if (obs_q.size() >= exp_q.size() && !txen_out) done = 1;
        end
        check({tag, " frame done"}, done, 1);
        repeat (16) @(posedge clk_in);
        #1;
        check({tag, " byte count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0)
            check({tag, " byte"}, obs_q.pop_front(), exp_q.pop_front());
        check({tag, " frame count"}, len_q.size(), exp_len_q.size());
        while (exp_len_q.size() > 0 && len_q.size() > 0)
            check({tag, " txen run"}, len_q.pop_front(), exp_len_q.pop_front());
        exp_q.delete();
        obs_q.delete();
        len_q.delete();
        exp_len_q.delete();
    endtask

    initial begin
        int   fw;
        int   rw;
        int   exp_sent;
        int   exp_drop;
        bit   found;
        q8_t  p;

        s_tdata_in  = 8'h00;
        s_tvalid_in = 1'b0;
        s_tlast_in  = 1'b0;
        rst_in      = 1'b1;
        exp_sent    = 0;
        exp_drop    = 0;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset txen", txen_out, 0);
        check("reset txd", txd_out, 0);
        check("reset tready", s_tready_out, 0);
        check("reset sent", stat_packet_sent_cnt, 0);
        check("reset drop", stat_packet_drop_cnt, 0);
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        check("tready after reset", s_tready_out, 1);

        // Minimum-size packet 01..08: checksum 0x72.
        p = make_pkt(8, 1, 0);
        push_frame(p);
        send_pkt(p, 0, fw, rw);
        compare_frames("pkt8");
        exp_sent++;
        check("sent after pkt8", stat_packet_sent_cnt, exp_sent);

        // Short packet AA BB CC: padded or dropped depending on build.
        p = '{8'hAA, 8'hBB, 8'hCC};
`ifdef SIMPLE_TX_PAD_EN
        push_frame(p);
        exp_sent++;
`else
        exp_drop++;
`endif
        send_pkt(p, 0, fw, rw);
        compare_frames("short");
        check("sent after short", stat_packet_sent_cnt, exp_sent);
        check("drop after short", stat_packet_drop_cnt, exp_drop);

        // Oversize 300-byte packet is swallowed without back-pressure.
        p = make_pkt(300, 0, 1);
        send_pkt(p, 0, fw, rw);
        check("oversize ready every beat", fw + rw, 0);
        exp_drop++;
        compare_frames("oversize");
        check("drop after oversize", stat_packet_drop_cnt, exp_drop);
        p = make_pkt(8, 8'hF0, 0);
        push_frame(p);
        send_pkt(p, 0, fw, rw);
        compare_frames("after oversize");
        exp_sent++;
        check("sent after oversize", stat_packet_sent_cnt, exp_sent);

        // Largest legal packet, then one byte more.
        p = make_pkt(255, 0, 1);
        push_frame(p);
        send_pkt(p, 0, fw, rw);
        compare_frames("pkt255");
        exp_sent++;
        p = make_pkt(256, 0, 1);
        send_pkt(p, 0, fw, rw);
        compare_frames("pkt256");
        exp_drop++;
        check("sent after 255/256", stat_packet_sent_cnt, exp_sent);
        check("drop after 255/256", stat_packet_drop_cnt, exp_drop);

        // Back-to-back 10-byte packets with tvalid held high.
        gap_q.delete();
        p = make_pkt(10, 8'h20, 0);
        push_frame(p);
        send_pkt(p, 1, fw, rw);
        p = make_pkt(10, 0, 1);
        push_frame(p);
        send_pkt(p, 0, fw, rw);
        check("b2b tready low cycles", fw, 30);
        compare_frames("b2b");
        check("b2b idle gap", (gap_q.size() == 2) ? gap_q[1] : -1, 22);
        exp_sent += 2;
        check("sent after b2b", stat_packet_sent_cnt, exp_sent);

        // Random lengths across the legal range.
        for (int k = 0; k < 4; k++) begin
            p = make_pkt($urandom_range(255, 8), 0, 1);
            push_frame(p);
            send_pkt(p, 0, fw, rw);
            compare_frames("random");
            exp_sent++;
        end
        check("sent after random", stat_packet_sent_cnt, exp_sent);
        check("drop after random", stat_packet_drop_cnt, exp_drop);

        // Reset while payload byte 3 is on the line.
        p = make_pkt(10, 8'h40, 0);
        send_pkt(p, 0, fw, rw);
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(posedge clk_in);
            #1;
            if (obs_q.size() >= 9) found = 1;
        end
        check("reached payload byte 3", found, 1);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("mid-frame reset txen", txen_out, 0);
        check("mid-frame reset txd", txd_out, 0);
        check("mid-frame reset sent", stat_packet_sent_cnt, 0);
        check("mid-frame reset drop", stat_packet_drop_cnt, 0);
        rst_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        obs_q.delete();
        len_q.delete();
        exp_q.delete();
        exp_len_q.delete();
        p = make_pkt(8, 8'h90, 0);
        push_frame(p);
        send_pkt(p, 0, fw, rw);
        compare_frames("after reset");
        check("sent after reset", stat_packet_sent_cnt, 1);
        check("drop after reset", stat_packet_drop_cnt, 0);

        check("txd zero while idle", idle_bad, 0);
        check("txer held low", txer_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
